// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the IF/ID stage and its hazard logic.
//   NOP            - all-zero instruction word used to squash a slot
//   RS_HI/RS_LO    - bit range of the rs field in an instruction word
//   RT_HI/RT_LO    - bit range of the rt field in an instruction word
//   hz_state_e     - load-use tracker state {RUN, STALL, ERR}
package mips_pkg;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    ERR   = 2'd2
  } hz_state_e;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: pure combinational load-use hazard equation. Shared with
// the forwarding unit, so it takes already-extracted register fields.
// Ports:
//   valid    in  1      consumer slot holds a real instruction
//   memread  in  1      a load sits in EX
//   idex_rt  in  REG_W  destination register of that load
//   rs, rt   in  REG_W  source fields of the consumer instruction
//   haz      out 1      consumer must wait one cycle
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic             valid,
  input  logic             memread,
  input  logic [REG_W-1:0] idex_rt,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  output logic             haz
);

  // r0 is hardwired to zero, so a load "into" it never creates a dependency.
  assign haz = valid & memread & (idex_rt != '0) &
               ((idex_rt == rs) | (idex_rt == rt));

endmodule

// File: rtl/ifid_hazard_reg.sv
// ifid_hazard_reg: IF/ID pipeline register with integrated load-use hazard
// detection. Holds the slot for one cycle on a load-use hazard (freezing the
// PC and requesting a bubble into ID/EX) and squashes to NOP on Flush.
// Optional build macro: HAZARD_STATS_EN adds StallCount/FlushCount outputs.
// Ports:
//   clk, rst                in   clock, asynchronous active-high reset
//   PCplusOne, Instr_in     in   DATA_W  PC+1 and fetched instruction from IF
//   Flush                   in   taken branch/jump, squash the IF slot
//   IDEX_MemRead, IDEX_rt   in   load-in-EX flag and its destination
//   PCplusOneOut, InstrOut  out  registered PC+1 / instruction to ID
//   ValidOut                out  InstrOut is a real instruction
//   PCWrite                 out  0 = hold the PC this cycle
//   Bubble                  out  1 = ID drives all-zero controls into ID/EX
//   StallCount, FlushCount  out  32-bit wrapping event counters (stats build)
module ifid_hazard_reg
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] PCplusOne,
  input  logic [DATA_W-1:0] Instr_in,
  input  logic              Flush,
  input  logic              IDEX_MemRead,
  input  logic [REG_W-1:0]  IDEX_rt,
  output logic [DATA_W-1:0] PCplusOneOut,
  output logic [DATA_W-1:0] InstrOut,
  output logic              ValidOut,
  output logic              PCWrite,
`ifdef HAZARD_STATS_EN
  output logic [31:0]       StallCount,
  output logic [31:0]       FlushCount,
`endif
  output logic              Bubble
);

  hz_state_e state;
  logic      haz;
  logic      stall_win;

  load_use_detect #(.REG_W(REG_W)) u_detect (
    .valid   (ValidOut),
    .memread (IDEX_MemRead),
    .idex_rt (IDEX_rt),
    .rs      (InstrOut[RS_LO +: REG_W]),
    .rt      (InstrOut[RT_LO +: REG_W]),
    .haz     (haz)
  );

  // Flush outranks the hazard: a squashed slot never needs to wait.
  assign stall_win = haz & ~Flush;

  // ERR means ID/EX kept a load alive past the bubble; keep the pipe moving
  // with bubbles rather than deadlock, until reset.
  always_comb begin
    PCWrite = ~haz | Flush;
    Bubble  = haz | ~ValidOut;
    if (state == ERR) begin
      PCWrite = 1'b1;
      Bubble  = 1'b1;
    end
  end

  // ---- IF -> ID stage boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCplusOneOut <= '0;
      InstrOut     <= DATA_W'(NOP);
      ValidOut     <= 1'b0;
    end else if (Flush) begin
      PCplusOneOut <= PCplusOne;
      InstrOut     <= DATA_W'(NOP);
      ValidOut     <= 1'b0;
    end else if (!haz) begin
      PCplusOneOut <= PCplusOne;
      InstrOut     <= Instr_in;
      ValidOut     <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     state <= stall_win ? STALL : RUN;
        STALL:   state <= stall_win ? ERR : RUN;
        ERR:     state <= ERR;
        default: state <= RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (stall_win) StallCount <= StallCount + 32'd1;
      if (Flush)     FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

endmodule
